// File: rtl/dmem_ctrl_if.sv
// Core-to-data-memory bus for dmem_ctrl: request, store data, load result and stall.
// The core drives the master side; the controller implements the slave side.
interface dmem_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rdata;
    logic        stall;

    modport master (
        output addr,
        output wdata,
        output mem_read,
        output mem_write,
        input  rdata,
        input  stall
    );

    modport slave (
        input  addr,
        input  wdata,
        input  mem_read,
        input  mem_write,
        output rdata,
        output stall
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Multi-cycle data memory controller that stalls the core while a word access completes.
// Define DMEM_WRITE_POST_EN to absorb stores into a one-entry posted-write buffer.
module dmem_ctrl #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input logic         clk,
    input logic         rst,
    dmem_ctrl_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic        reqWrite;
    logic [31:0] rdataReg;

    logic request;
    logic inRange;
    logic postAccept;
    logic bufBusy;

    assign request = bus.mem_read | bus.mem_write;
    assign inRange = (reqAddr < 32'(DEPTH));

`ifdef DMEM_WRITE_POST_EN
    logic        pbValid;
    logic [31:0] pbAddr;
    logic [31:0] pbData;
    logic [3:0]  pbCnt;
    logic        pbInRange;

    assign pbInRange  = (pbAddr < 32'(DEPTH));
    assign bufBusy    = pbValid;
    assign postAccept = (state == IDLE) & bus.mem_write & ~pbValid;
`else
    assign bufBusy    = 1'b0;
    assign postAccept = 1'b0;
`endif

    assign bus.stall = ((state == IDLE) & request & ~postAccept) | (state == BUSY);
    assign bus.rdata = rdataReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            reqAddr  <= '0;
            reqData  <= '0;
            reqWrite <= 1'b0;
            rdataReg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
`ifdef DMEM_WRITE_POST_EN
            pbValid <= 1'b0;
            pbAddr  <= '0;
            pbData  <= '0;
            pbCnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (request && !bufBusy && !postAccept) begin
                        reqAddr  <= bus.addr;
                        reqData  <= bus.wdata;
                        reqWrite <= bus.mem_write;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Out-of-range stores vanish and out-of-range loads read as zero.
                        if (reqWrite) begin
                            if (inRange) begin
                                mem[reqAddr[AW-1:0]] <= reqData;
                            end
                        end else begin
                            rdataReg <= inRange ? mem[reqAddr[AW-1:0]] : 32'd0;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef DMEM_WRITE_POST_EN
            // The buffer only fills from IDLE with no access in flight, so its drain never collides with a BUSY access.
            if (pbValid) begin
                if (pbCnt != 4'd0) begin
                    pbCnt <= pbCnt - 4'd1;
                end else begin
                    if (pbInRange) begin
                        mem[pbAddr[AW-1:0]] <= pbData;
                    end
                    pbValid <= 1'b0;
                end
            end else if (postAccept) begin
                pbValid <= 1'b1;
                pbAddr  <= bus.addr;
                pbData  <= bus.wdata;
                pbCnt   <= 4'(LATENCY - 1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (default build, no posted writes): directed cases plus
// random loads/stores against a word-array reference model with per-access stall counting.
module tb_dmem_ctrl;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_ctrl_if bus ();

    dmem_ctrl #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] modelMem [DEPTH];
    logic [31:0] expRdata;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            modelMem[i] = 32'd0;
        end
        expRdata = 32'd0;
    endtask

    // One full core access: hold the request until stall drops, then release it like the core would.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input string tag);
        int  stallCycles;
        bit  done;
        stallCycles = 0;
        done        = 1'b0;
        bus.addr      = a;
        bus.wdata     = d;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        if (wr) begin
            if (a < 32'(DEPTH)) modelMem[a[9:0]] = d;
        end else if (rd) begin
            expRdata = (a < 32'(DEPTH)) ? modelMem[a[9:0]] : 32'd0;
        end
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (bus.stall) stallCycles++;
            else done = 1'b1;
        end
        checkOutput({tag, " completed"}, 32'(done), 32'd1);
        checkOutput({tag, " stall cycles"}, 32'(stallCycles), 32'(LATENCY + 1));
        checkOutput({tag, " rdata"}, bus.rdata, expRdata);
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput({tag, " idle stall"}, 32'(bus.stall), 32'd0);
        checkOutput({tag, " idle rdata"}, bus.rdata, expRdata);
        @(posedge clk);
        #1;
    endtask

    task automatic resetMidStore(input logic [31:0] a, input logic [31:0] d);
        bus.addr      = a;
        bus.wdata     = d;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.mem_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          r;
        rst           = 1'b1;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("reset");

        applyStimulus(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, "store5");
        applyStimulus(1'b1, 1'b0, 32'd5, 32'd0, "load5");

        applyStimulus(1'b0, 1'b1, 32'd1, 32'h11, "store1");
        applyStimulus(1'b0, 1'b1, 32'd2, 32'h22, "store2");
        applyStimulus(1'b1, 1'b0, 32'd1, 32'd0, "load1");
        applyStimulus(1'b1, 1'b0, 32'd2, 32'd0, "load2");
        checkIdle("after load2");

        applyStimulus(1'b0, 1'b1, 32'd0, 32'h0BAD_F00D, "store0");
        applyStimulus(1'b1, 1'b0, 32'd2048, 32'd0, "load2048");
        applyStimulus(1'b0, 1'b1, 32'd2048, 32'hCAFE_F00D, "store2048");
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, "load0 alias");
        applyStimulus(1'b1, 1'b0, 32'd1023, 32'd0, "load1023");

        applyStimulus(1'b1, 1'b0, 32'd5, 32'd0, "load5 again");
        applyStimulus(1'b1, 1'b1, 32'd3, 32'hAA, "both3");
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd0, "load3");

        applyStimulus(1'b0, 1'b1, 32'd4, 32'h5555_AAAA, "store4");
        resetMidStore(32'd7, 32'h1234);
        checkIdle("after abort");
        applyStimulus(1'b1, 1'b0, 32'd7, 32'd0, "load7");
        applyStimulus(1'b1, 1'b0, 32'd4, 32'd0, "load4 cleared");

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 7) == 0) ? 32'(DEPTH) + 32'($urandom_range(0, 5000))
                                            : 32'($urandom_range(0, 15));
            d = $urandom;
            if (r < 4)      applyStimulus(1'b1, 1'b0, a, d, "rand load");
            else if (r < 8) applyStimulus(1'b0, 1'b1, a, d, "rand store");
            else            applyStimulus(1'b1, 1'b1, a, d, "rand both");
            if ($urandom_range(0, 3) == 0) checkIdle("rand gap");
        end

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 32'(i), 32'd0, "sweep load");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of 32-bit data words.
REQ-002 SHALL have parameter LATENCY, default 2: array access cycles, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port addr, input, 32: word index from the core's MEM stage ALU result.
REQ-006 SHALL have port wdata, input, 32: store data.
REQ-007 SHALL have port mem_read, input, 1: load request, held by the core while stalled.
REQ-008 SHALL have port mem_write, input, 1: store request, held by the core while stalled.
REQ-009 SHALL have port rdata, output, 32: load result, registered.
REQ-010 SHALL have port stall, output, 1: 1 freezes the core's PC, fetch and pipeline registers this cycle.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE; stall = (IDLE & (mem_read|mem_write) & ~posted-write accept) | BUSY.
REQ-012 In IDLE with a request, the FSM SHALL latch addr/wdata/op, load cnt = LATENCY-1 and go to BUSY.
REQ-013 In BUSY with cnt>0, the FSM SHALL decrement cnt; with cnt==0 it SHALL perform the access and go to DONE.
REQ-014 In DONE, stall SHALL be 0, rdata SHALL hold the load result, and the FSM SHALL return to IDLE unconditionally, ignoring the still-present request.
REQ-015 Non-posted access SHALL stall exactly LATENCY+1 cycles; the next request is accepted no earlier than the cycle after DONE.
REQ-016 mem_read and mem_write both 1 SHALL be treated as a write; rdata unchanged.
REQ-017 addr >= DEPTH SHALL complete with normal timing; writes discarded, reads return 0.
REQ-018 rdata SHALL change only on load completion; stores and idle cycles leave it unchanged.
REQ-019 Request inputs SHALL be ignored outside IDLE; only latched values are used.

Reset
REQ-020 rst SHALL force state IDLE, cnt 0, rdata 0, stall 0 next cycle, and clear all DEPTH words to 0.
REQ-021 rst during BUSY SHALL abort the access; an uncommitted store SHALL not reach the array.
REQ-022 Posted-write buffer (if compiled) SHALL be cleared by rst without draining.

Configuration
REQ-023 Macro DMEM_WRITE_POST_EN SHALL select posted stores.
REQ-024 With DMEM_WRITE_POST_EN: a store in IDLE with empty buffer SHALL enter a 1-entry buffer with stall 0 and drain to the array after LATENCY cycles.
REQ-025 With DMEM_WRITE_POST_EN: any request while the buffer is non-empty SHALL stall until drain completes, then proceed per REQ-012.
REQ-026 Without DMEM_WRITE_POST_EN: stores SHALL follow REQ-012..REQ-015; no buffer logic present.

Verification
REQ-027 LATENCY=2, store addr=5 wdata=0xDEADBEEF held -> stall 1 for 3 cycles, then 0; later load addr=5 -> rdata=0xDEADBEEF in DONE cycle.
REQ-028 Back-to-back loads addr=1 then addr=2 (mem[1]=0x11, mem[2]=0x22) -> each stalls 3 cycles, rdata 0x11 then 0x22, no re-trigger of load 1.
REQ-029 Load addr=2048 (DEPTH=1024) -> normal timing, rdata=0; store addr=2048 -> no word modified.
REQ-030 rst asserted in 2nd BUSY cycle of store addr=7 wdata=0x1234 -> IDLE, stall 0, mem[7]=0 after reset.
REQ-031 mem_read=mem_write=1, addr=3, wdata=0xAA -> mem[3]=0xAA, rdata unchanged.
REQ-032 DMEM_WRITE_POST_EN, LATENCY=4: store addr=9 then immediate load addr=9 -> store stall 0, load stalls until drain, rdata equals stored value.
